// File: rtl/cosim_stim_pkg.sv
// Shared types, constants and LFSR helpers for the cosim stimulus source
// and the response-signature stage that reuses its LFSR.
package cosim_stim_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXH  = 2'd1,
    RAND = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [31:0] LFSR_POLY = 32'h80200003;

  // Per-word masks applied to the LFSR state to build one 128-bit vector.
  localparam logic [31:0] WORD_XOR0 = 32'h00000000;
  localparam logic [31:0] WORD_XOR1 = 32'h5A5A5A5A;
  localparam logic [31:0] WORD_XOR2 = 32'hFFFFFFFF;
  localparam logic [31:0] WORD_XOR3 = 32'hC3C3C3C3;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_POLY : 32'h0);
  endfunction

  // A zero seed would lock the LFSR, so it is replaced by 1.
  function automatic logic [31:0] seed_fix(input logic [31:0] s);
    return (s == 32'h0) ? 32'h00000001 : s;
  endfunction

  function automatic logic [127:0] rand_vec(input logic [31:0] s);
    return {s ^ WORD_XOR3, s ^ WORD_XOR2, s ^ WORD_XOR1, s ^ WORD_XOR0};
  endfunction

endpackage

// File: rtl/cosim_lfsr32.sv
// 32-bit Galois LFSR with synchronous seed load and gated advance.
module cosim_lfsr32
  import cosim_stim_pkg::*;
#(
  parameter logic [31:0] SEED = 32'h00000001
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        advance,
  output logic [31:0] state
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= seed_fix(SEED);
    end else if (load) begin
      state <= seed_fix(seed);
    end else if (advance) begin
      state <= lfsr_next(state);
    end
  end

endmodule

// File: rtl/cosim_stim_gen.sv
// Stimulus source: exhaustive sweep of the low input bits, then LFSR-driven
// random vectors, offered over valid/ready with all outputs registered.
module cosim_stim_gen
  import cosim_stim_pkg::*;
#(
  parameter int unsigned EXH_BITS = 5,
  parameter int unsigned NRAND    = 256,
  parameter logic [31:0] SEED     = 32'h00000001
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic         vec_valid,
  input  logic         vec_ready,
  output logic [127:0] vec_data,
  output logic [31:0]  vec_idx
);

  state_t              state;
  logic [EXH_BITS-1:0] exh_cnt;
  logic [31:0]         rand_cnt;
  logic [31:0]         lfsr_q;
  logic                xfer;
  logic                go;
  logic                lfsr_adv;

  assign xfer     = vec_valid && vec_ready;
  assign go       = start && ((state == IDLE) || (state == DONE));
  assign lfsr_adv = (state == RAND) && xfer;

  cosim_lfsr32 #(.SEED(SEED)) u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (go),
    .seed    (SEED),
    .advance (lfsr_adv),
    .state   (lfsr_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      vec_valid <= 1'b0;
      vec_data  <= '0;
      vec_idx   <= '0;
      exh_cnt   <= '0;
      rand_cnt  <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= EXH;
            busy      <= 1'b1;
            done      <= 1'b0;
            vec_valid <= 1'b1;
            vec_data  <= '0;
            vec_idx   <= '0;
            exh_cnt   <= '0;
            rand_cnt  <= '0;
          end
        end
        EXH: begin
          if (xfer) begin
            vec_idx <= vec_idx + 32'd1;
            if (&exh_cnt) begin
              // The LFSR still holds the seed here, so the first random
              // vector is presented with no bubble.
              if (NRAND > 0) begin
                state    <= RAND;
                vec_data <= rand_vec(lfsr_q);
              end else begin
                state     <= DONE;
                busy      <= 1'b0;
                done      <= 1'b1;
                vec_valid <= 1'b0;
              end
            end else begin
              exh_cnt  <= exh_cnt + EXH_BITS'(1);
              vec_data <= 128'(exh_cnt + EXH_BITS'(1));
            end
          end
        end
        RAND: begin
          if (xfer) begin
            vec_idx  <= vec_idx + 32'd1;
            rand_cnt <= rand_cnt + 32'd1;
            if (rand_cnt == NRAND - 1) begin
              state     <= DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
              vec_valid <= 1'b0;
            end else begin
              vec_data <= rand_vec(lfsr_next(lfsr_q));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cosim_stim_gen.sv
// Bench for cosim_stim_gen: directed runs with random ready/start, checked
// against a precomputed table of the expected vector sequence.
module tb_cosim_stim_gen;

  localparam int NR   = 64;
  localparam int NVEC = 32 + NR;
  localparam logic [31:0] TB_SEED = 32'h00000001;

  logic         clk = 1'b0;
  logic         rst_n, start, vec_ready;
  logic         busy, done, vec_valid;
  logic [127:0] vec_data;
  logic [31:0]  vec_idx;

  logic         start_b, ready_b;
  logic         busy_b, done_b, valid_b;
  logic [127:0] data_b;
  logic [31:0]  idx_b;

  int checks = 0;
  int errors = 0;
  logic [127:0] expv [NVEC];

  always #5 clk = ~clk;

  cosim_stim_gen #(.EXH_BITS(5), .NRAND(NR), .SEED(TB_SEED)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .vec_valid(vec_valid), .vec_ready(vec_ready), .vec_data(vec_data),
    .vec_idx(vec_idx)
  );

  cosim_stim_gen #(.EXH_BITS(5), .NRAND(0), .SEED(TB_SEED)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .busy(busy_b), .done(done_b),
    .vec_valid(valid_b), .vec_ready(ready_b), .vec_data(data_b),
    .vec_idx(idx_b)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_valid"}, vec_valid, 0);
    chk({tag, "_data"}, vec_data, 0);
    chk({tag, "_idx"}, vec_idx, 0);
  endtask

  // mode 0: ready high; 1: random ready and start; 2: stall at vector 5;
  // 3: reset pulse while vector 40 is on offer.
  task automatic run(input int mode);
    int n, budget, stall;
    bit aborted;
    n = 0; budget = 0; stall = 0; aborted = 0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("latency_valid", vec_valid, 1);
    chk("first_idx", vec_idx, 0);
    chk("first_data", vec_data, 0);
    chk("busy_high", busy, 1);
    while (!done && budget < 2000) begin
      budget++;
      vec_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (mode == 1) start = 1'($urandom_range(0, 1));
      if (mode == 0) chk("no_gap", vec_valid, 1);
      if (mode == 2 && vec_valid && vec_idx == 5 && stall < 2) begin
        vec_ready = 1'b0;
        stall++;
        chk("stall_data", vec_data, expv[5]);
        chk("stall_idx", vec_idx, 5);
      end
      if (mode == 3 && vec_idx == 40) begin
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("async_reset");
        cyc();
        rst_n = 1'b1;
        aborted = 1;
        break;
      end
      if (vec_valid && vec_ready) begin
        chk("xfer_in_range", n < NVEC, 1);
        if (n < NVEC) begin
          chk("vec_data", vec_data, expv[n]);
          chk("vec_idx", vec_idx, n);
        end
        if (n == 32) begin
          chk("r0_w0", vec_data[31:0], 32'h00000001);
          chk("r0_w1", vec_data[63:32], 32'h5A5A5A5B);
          chk("r0_w2", vec_data[95:64], 32'hFFFFFFFE);
          chk("r0_w3", vec_data[127:96], 32'hC3C3C3C2);
        end
        if (n == 33) chk("r1_w0", vec_data[31:0], 32'h80200003);
        n++;
      end
      cyc();
    end
    start = 1'b0;
    vec_ready = 1'b0;
    if (!aborted) begin
      chk("end_done", done, 1);
      chk("end_busy", busy, 0);
      chk("end_valid", vec_valid, 0);
      chk("xfer_count", n, NVEC);
      chk("done_holds_last", vec_data, expv[NVEC-1]);
    end
  endtask

  initial begin
    logic [31:0] s;
    int n, budget;
    rst_n = 1'b0; start = 1'b0; vec_ready = 1'b0;
    start_b = 1'b0; ready_b = 1'b0;

    s = (TB_SEED == 0) ? 32'h1 : TB_SEED;
    for (int i = 0; i < NVEC; i++) begin
      if (i < 32) begin
        expv[i] = 128'(i);
      end else begin
        expv[i] = {s ^ 32'hC3C3C3C3, ~s, s ^ 32'h5A5A5A5A, s};
        s = s[0] ? ((s >> 1) ^ 32'h80200003) : (s >> 1);
      end
    end

    #1 chk_reset_vals("reset");
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("idle_valid", vec_valid, 0);

    run(0);
    run(2);
    run(1);
    run(3);
    run(0);

    start_b = 1'b1;
    cyc();
    start_b = 1'b0;
    ready_b = 1'b1;
    n = 0; budget = 0;
    while (!done_b && budget < 200) begin
      budget++;
      if (valid_b) begin
        chk("nr0_data", data_b, (n < 32) ? expv[n] : 128'hx);
        n++;
      end
      cyc();
    end
    ready_b = 1'b0;
    chk("nr0_done", done_b, 1);
    chk("nr0_busy", busy_b, 0);
    chk("nr0_valid", valid_b, 0);
    chk("nr0_count", n, 32);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
